// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes, register ids, status FSM states.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_t;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [1:0] {
        FSM_RUN    = 2'd0,
        FSM_HALTED = 2'd1,
        FSM_FAULT  = 2'd2
    } fsm_t;

    // Exception codes that stop the machine in FAULT rather than HALTED.
    function automatic logic is_fault(input logic [2:0] s);
        return (s == ADR) || (s == INS);
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: two combinational read ports, two write ports.
// Port M beats port E on the same index; index RNONE is never stored and reads as 0.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] rvalA,
    output logic [DATA_W-1:0] rvalB,
    input  logic              weE,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic              weM,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Next register contents: E applied first so M overrides it (popq %rsp).
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (weE && dstE == 4'(i)) regs_d[i] = valE;
            if (weM && dstM == 4'(i)) regs_d[i] = valM;
        end
    end

    // Register storage; reset seeds R[i] = i.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_W'(i);
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports see the pre-write value; RNONE falls through to 0.
    always_comb begin
        rvalA = '0;
        rvalB = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA == 4'(i)) rvalA = regs_q[i];
            if (srcB == 4'(i)) rvalB = regs_q[i];
        end
    end

endmodule

// File: rtl/y86_writeback.sv
// Y86-64 write-back stage: W pipeline register, register-file commit, processor-status FSM.
// Optional: define Y86_RETIRE_COUNT_EN to build the saturating retired-instruction counter.
module y86_writeback
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        m_stat,
    input  logic [3:0]        m_icode,
    input  logic [DATA_W-1:0] m_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        m_dstE,
    input  logic [3:0]        m_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] rvalA,
    output logic [DATA_W-1:0] rvalB,
    output logic [3:0]        W_icode,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [63:0]       retired
);

    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
        logic [DATA_W-1:0] valE;
        logic [DATA_W-1:0] valM;
    } w_reg_t;

    localparam w_reg_t W_NOP = '{AOK, I_NOP, RNONE, RNONE, {DATA_W{1'b0}}, {DATA_W{1'b0}}};

    w_reg_t     w_q, w_d, w_m;
    fsm_t       state_q, state_d;
    logic [2:0] stat_q, stat_d;
    logic       adv, run, we;

    assign w_m = '{m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM};
    assign adv = !W_stall;
    assign run = (state_q == FSM_RUN);
    // Commit only on the edge that retires W, while running, for a clean instruction.
    assign we  = adv && run && (w_q.stat == AOK);

    // W register next value: stall holds, bubble injects NOP, else load from memory stage.
    always_comb begin
        w_d = w_q;
        if (adv) w_d = W_bubble ? W_NOP : w_m;
    end

    // W register.
    always_ff @(posedge clk) begin
        if (rst) w_q <= W_NOP;
        else     w_q <= w_d;
    end

    // Status FSM next state: HLT or an exception in W stops the machine for good.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        if (adv && run) begin
            if (w_q.stat == HLT) begin
                state_d = FSM_HALTED;
                stat_d  = HLT;
            end else if (is_fault(w_q.stat)) begin
                state_d = FSM_FAULT;
                stat_d  = w_q.stat;
            end
        end
    end

    // Status FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FSM_RUN;
            stat_q  <= AOK;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
        end
    end

    y86_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .srcA  (srcA),
        .srcB  (srcB),
        .rvalA (rvalA),
        .rvalB (rvalB),
        .weE   (we && (w_q.dstE != RNONE)),
        .dstE  (w_q.dstE),
        .valE  (w_q.valE),
        .weM   (we && (w_q.dstM != RNONE)),
        .dstM  (w_q.dstM),
        .valM  (w_q.valM)
    );

`ifdef Y86_RETIRE_COUNT_EN
    logic [63:0] retired_q, retired_d;
    logic        cnt_en;

    // HLT retires (once, since the FSM leaves RUN); bubbles and faults do not.
    assign cnt_en = adv && run && (w_q.icode != I_NOP) &&
                    ((w_q.stat == AOK) || (w_q.stat == HLT));

    // Saturating increment.
    always_comb begin
        retired_d = retired_q;
        if (cnt_en && (retired_q != '1)) retired_d = retired_q + 64'd1;
    end

    // Retired counter register.
    always_ff @(posedge clk) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

    assign W_icode = w_q.icode;
    assign W_dstE  = w_q.dstE;
    assign W_dstM  = w_q.dstM;
    assign W_valE  = w_q.valE;
    assign W_valM  = w_q.valM;
    assign stat    = stat_q;
    assign halted  = (state_q != FSM_RUN);

endmodule

// File: tb/tb_y86_writeback.sv
// Self-checking bench for y86_writeback: directed scenarios, then random traffic
// against an instruction-level model of register file, status and retire count.
module tb_y86_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic [63:0] m_valE, m_valM;
    logic [3:0]  m_dstE, m_dstM;
    logic        W_stall, W_bubble;
    logic [3:0]  srcA, srcB;
    logic [63:0] rvalA, rvalB;
    logic [3:0]  W_icode, W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    y86_writeback dut (
        .clk(clk), .rst(rst),
        .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_dstE(m_dstE), .m_dstM(m_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
        .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM),
        .stat(stat), .halted(halted), .retired(retired)
    );

    // Reference model: architectural registers, in-flight W instruction, machine status.
    logic [63:0] mr [15];
    logic [2:0]  wst;
    logic [3:0]  wic, wde, wdm;
    logic [63:0] wve, wvm;
    bit          mrun;
    logic [2:0]  mstat;
    logic [63:0] mret;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mread(input logic [3:0] a);
        return (a == 4'hF) ? 64'd0 : mr[a];
    endfunction

    function automatic logic [63:0] exp_ret();
`ifdef Y86_RETIRE_COUNT_EN
        return mret;
`else
        return 64'd0;
`endif
    endfunction

    task automatic w_nop();
        wst = 3'd1; wic = 4'h1; wde = 4'hF; wdm = 4'hF; wve = '0; wvm = '0;
    endtask

    // One clock edge of architectural behaviour, using the inputs held across it.
    task automatic model_tick();
        if (rst) begin
            for (int i = 0; i < 15; i++) mr[i] = 64'(i);
            w_nop();
            mrun = 1; mstat = 3'd1; mret = 0;
        end else if (!W_stall) begin
            if (mrun && wst == 3'd1) begin
                if (wde != 4'hF) mr[wde] = wve;
                if (wdm != 4'hF) mr[wdm] = wvm;
            end
            if (mrun && wic != 4'h1 && (wst == 3'd1 || wst == 3'd2) && mret != '1)
                mret = mret + 1;
            if (mrun && wst inside {3'd2, 3'd3, 3'd4}) begin
                mrun  = 0;
                mstat = wst;
            end
            if (W_bubble) w_nop();
            else begin
                wst = m_stat; wic = m_icode; wde = m_dstE; wdm = m_dstM;
                wve = m_valE; wvm = m_valM;
            end
        end
    endtask

    task automatic cmp_all();
        chk("rvalA",   rvalA,   mread(srcA));
        chk("rvalB",   rvalB,   mread(srcB));
        chk("W_icode", W_icode, wic);
        chk("W_dstE",  W_dstE,  wde);
        chk("W_dstM",  W_dstM,  wdm);
        chk("W_valE",  W_valE,  wve);
        chk("W_valM",  W_valM,  wvm);
        chk("stat",    stat,    mstat);
        chk("halted",  halted,  !mrun);
        chk("retired", retired, exp_ret());
    endtask

    // Inputs are driven just after negedge; outputs checked, then the edge is modelled.
    task automatic cycle();
        #1 cmp_all();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic set_m(input logic [2:0] s, input logic [3:0] ic, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
        m_stat = s; m_icode = ic; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) begin
            @(posedge clk);
            model_tick();
            @(negedge clk);
        end
        rst = 0;
    endtask

    initial begin
        logic [3:0] d;
        rst = 1; W_stall = 0; W_bubble = 0; srcA = 4'd3; srcB = 4'hF;
        set_m(3'd1, 4'h1, 4'hF, 4'hF, 0, 0);
        do_reset();

        // reset state
        #1;
        chk("rst_rvalA", rvalA, 64'd3);
        chk("rst_rvalB", rvalB, 64'd0);
        chk("rst_stat",  stat,  64'd1);
        chk("rst_icode", W_icode, 64'd1);
        chk("rst_ret",   retired, 64'd0);
        cycle();

        // OPQ write, old value visible while in W
        set_m(3'd1, 4'h6, 4'd2, 4'hF, 64'h55, 0); srcA = 4'd2;
        cycle();
        set_m(3'd1, 4'h1, 4'hF, 4'hF, 0, 0);
        #1 chk("opq_old", rvalA, 64'd2);
        chk("opq_wdst", W_dstE, 64'd2);
        cycle();
        #1 chk("opq_new", rvalA, 64'h55);

        // popq %rsp: valM wins
        set_m(3'd1, 4'hB, 4'd4, 4'd4, 64'h108, 64'hAA);
        cycle();
        set_m(3'd1, 4'h1, 4'hF, 4'hF, 0, 0);
        cycle();
        srcA = 4'd4;
        #1 chk("popq_rsp", rvalA, 64'hAA);

        // stall holds W, stall+bubble still holds
        set_m(3'd1, 4'h6, 4'd5, 4'hF, 64'h77, 0); srcA = 4'd5; srcB = 4'd6;
        cycle();
        W_stall = 1;
        set_m(3'd1, 4'h6, 4'd6, 4'hF, 64'h99, 0);
        repeat (3) cycle();
        W_bubble = 1;
        cycle();
        #1 chk("stall_dstE", W_dstE, 64'd5);
        chk("stall_valE", W_valE, 64'h77);
        W_stall = 0; W_bubble = 0;
        set_m(3'd1, 4'h1, 4'hF, 4'hF, 0, 0);
        cycle();
        #1 chk("stall_commit", rvalA, 64'h77);
        chk("stall_drop", rvalB, 64'd6);
        chk("stall_icode", W_icode, 64'd1);

        // ADR: no write, FAULT is sticky
        set_m(3'd3, 4'h6, 4'd1, 4'hF, 64'hDEAD, 0); srcA = 4'd1; srcB = 4'd7;
        cycle();
        set_m(3'd1, 4'h6, 4'd7, 4'hF, 64'h123, 0);
        cycle();
        set_m(3'd1, 4'h1, 4'hF, 4'hF, 0, 0);
        cycle();
        #1 chk("adr_r1", rvalA, 64'd1);
        chk("adr_r7", rvalB, 64'd7);
        chk("adr_stat", stat, 64'd3);
        chk("adr_halted", halted, 64'd1);

        // retire count: 4 OPQ + 2 bubbles + HLT
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_m(3'd1, 4'h6, 4'($urandom_range(0, 14)), 4'hF, {$urandom, $urandom}, 0);
            cycle();
        end
        set_m(3'd1, 4'h1, 4'hF, 4'hF, 0, 0);
        cycle();
        W_bubble = 1;
        cycle();
        W_bubble = 0;
        set_m(3'd2, 4'h0, 4'hF, 4'hF, 0, 0);
        cycle();
        set_m(3'd1, 4'h1, 4'hF, 4'hF, 0, 0);
        repeat (3) cycle();
`ifdef Y86_RETIRE_COUNT_EN
        #1 chk("ret_count", retired, 64'd5);
`else
        #1 chk("ret_count", retired, 64'd0);
`endif
        chk("hlt_stat", stat, 64'd2);
        chk("hlt_halted", halted, 64'd1);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 119) == 0);
            W_stall  = ($urandom_range(0, 4) == 0);
            W_bubble = ($urandom_range(0, 5) == 0);
            srcA     = 4'($urandom_range(0, 15));
            srcB     = 4'($urandom_range(0, 15));
            m_icode  = 4'($urandom_range(0, 11));
            m_stat   = ($urandom_range(0, 99) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            m_dstE   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            d        = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            m_dstM   = ($urandom_range(0, 7) == 0) ? m_dstE : d;
            m_valE   = {$urandom, $urandom};
            m_valM   = {$urandom, $urandom};
            cycle();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
